// File: rtl/frame_sample_indexer.sv
// frame_sample_indexer
// Registers each incoming audio word and tags it with its channel, global
// sample index, frame index and in-frame position, plus frame/stream strobes
// for the downstream windowing/FFT stage. Interleaved channels share one
// sample index; the sample-level counters step after the last channel.
//
// The internal counters always hold the indices of the *next* word to be
// accepted. The output registers capture those indices on acceptance, so
// the tags appear exactly one cycle after the word arrives.

module frame_sample_indexer #(
    parameter  int I_BW       = 14,
    parameter  int O_BW       = 14,
    parameter  int TOTAL_DATA = 15104,
    parameter  int FRAME_LEN  = 512,
    parameter  int NUM_CH     = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int NUM_W      = (TOTAL_DATA > 1) ? $clog2(TOTAL_DATA) : 1,
    localparam int FRM_W      = $clog2(TOTAL_DATA / FRAME_LEN + 1),
    localparam int POS_W      = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             di_en,
    input  logic [I_BW-1:0]  data_i,
    output logic             do_en,
    output logic [O_BW-1:0]  data_o,
    output logic [CH_W-1:0]  ch,
    output logic [NUM_W-1:0] num,
    output logic [FRM_W-1:0] frm_idx,
    output logic [POS_W-1:0] pos,
    output logic             sof,
    output logic             eof,
    output logic             last,
    output logic             done
);

    // Terminal values, sized to the counters they are compared against
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(TOTAL_DATA - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE  = NUM_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    // Index counters for the next word to be accepted
    logic [CH_W-1:0]  r_ch_cnt;
    logic [NUM_W-1:0] r_num_cnt;
    logic [FRM_W-1:0] r_frm_cnt;
    logic [POS_W-1:0] r_pos_cnt;

    // Output registers
    logic             r_do_en;
    logic [O_BW-1:0]  r_data;
    logic [CH_W-1:0]  r_ch;
    logic [NUM_W-1:0] r_num;
    logic [FRM_W-1:0] r_frm;
    logic [POS_W-1:0] r_pos;
    logic             r_sof;
    logic             r_eof;
    logic             r_last;
    logic             r_done;

    // Combinational helpers
    logic             w_accept;
    logic             w_ch_wrap;
    logic             w_pos_wrap;
    logic             w_num_wrap;
    logic             w_sof;
    logic             w_eof;
    logic             w_last;
    logic [CH_W-1:0]  w_ch_next;
    logic [NUM_W-1:0] w_num_next;
    logic [FRM_W-1:0] w_frm_next;
    logic [POS_W-1:0] w_pos_next;

    // A clear or a finished stream both block acceptance
    assign w_accept   = di_en & ~clr & ~r_done;

    assign w_ch_wrap  = (r_ch_cnt  == CH_LAST);
    assign w_pos_wrap = (r_pos_cnt == POS_LAST);
    assign w_num_wrap = (r_num_cnt == NUM_LAST);

    // Strobes describe the word being accepted now; the stream end also
    // closes a short final frame
    assign w_sof  = (r_pos_cnt == '0) & (r_ch_cnt == '0);
    assign w_last = w_num_wrap & w_ch_wrap;
    assign w_eof  = (w_pos_wrap & w_ch_wrap) | w_last;

    // Next counter values: channel steps every word, sample-level counters
    // step after the last channel; everything returns to 0 at stream end
    always_comb begin
        w_ch_next  = r_ch_cnt;
        w_num_next = r_num_cnt;
        w_frm_next = r_frm_cnt;
        w_pos_next = r_pos_cnt;
        if (w_accept) begin
            if (w_ch_wrap) begin
                w_ch_next = '0;
                if (w_num_wrap) begin
                    w_num_next = '0;
                    w_frm_next = '0;
                    w_pos_next = '0;
                end else begin
                    w_num_next = r_num_cnt + NUM_ONE;
                    if (w_pos_wrap) begin
                        w_pos_next = '0;
                        w_frm_next = r_frm_cnt + FRM_ONE;
                    end else begin
                        w_pos_next = r_pos_cnt + POS_ONE;
                    end
                end
            end else begin
                w_ch_next = r_ch_cnt + CH_ONE;
            end
        end
    end

    // Counter state; clear returns the stream to index 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_cnt  <= '0;
            r_num_cnt <= '0;
            r_frm_cnt <= '0;
            r_pos_cnt <= '0;
        end else if (clr) begin
            r_ch_cnt  <= '0;
            r_num_cnt <= '0;
            r_frm_cnt <= '0;
            r_pos_cnt <= '0;
        end else begin
            r_ch_cnt  <= w_ch_next;
            r_num_cnt <= w_num_next;
            r_frm_cnt <= w_frm_next;
            r_pos_cnt <= w_pos_next;
        end
    end

    // Valid and strobes pulse for one cycle per accepted word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_do_en <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_do_en <= w_accept;
            r_sof   <= w_accept & w_sof;
            r_eof   <= w_accept & w_eof;
            r_last  <= w_accept & w_last;
        end
    end

    // Done is a level: set with the final word, released only by clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else if (clr) begin
            r_done <= 1'b0;
        end else if (w_accept & w_last) begin
            r_done <= 1'b1;
        end
    end

    // Sample and index outputs capture on acceptance and hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_ch   <= '0;
            r_num  <= '0;
            r_frm  <= '0;
            r_pos  <= '0;
        end else if (w_accept) begin
            r_data <= O_BW'($signed(data_i));
            r_ch   <= r_ch_cnt;
            r_num  <= r_num_cnt;
            r_frm  <= r_frm_cnt;
            r_pos  <= r_pos_cnt;
        end
    end

    assign do_en   = r_do_en;
    assign data_o  = r_data;
    assign ch      = r_ch;
    assign num     = r_num;
    assign frm_idx = r_frm;
    assign pos     = r_pos;
    assign sof     = r_sof;
    assign eof     = r_eof;
    assign last    = r_last;
    assign done    = r_done;

endmodule

// File: tb/tb_frame_sample_indexer.sv
// Testbench for frame_sample_indexer: stimulus pushes expected tagged words
// into a queue; a negedge monitor pops and compares on every do_en and checks
// hold/zero behaviour on every other cycle.

module tb_frame_sample_indexer;

    localparam int I_BW       = 4;
    localparam int O_BW       = 8;
    localparam int TOTAL_DATA = 10;
    localparam int FRAME_LEN  = 4;
    localparam int NUM_CH     = 2;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       di_en;
    logic [3:0] data_i;
    logic       do_en;
    logic [7:0] data_o;
    logic [0:0] ch;
    logic [3:0] num;
    logic [1:0] frm_idx;
    logic [1:0] pos;
    logic       sof;
    logic       eof;
    logic       last;
    logic       done;

    frame_sample_indexer #(
        .I_BW(I_BW), .O_BW(O_BW), .TOTAL_DATA(TOTAL_DATA),
        .FRAME_LEN(FRAME_LEN), .NUM_CH(NUM_CH)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .di_en(di_en), .data_i(data_i),
        .do_en(do_en), .data_o(data_o), .ch(ch), .num(num),
        .frm_idx(frm_idx), .pos(pos), .sof(sof), .eof(eof),
        .last(last), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [0:0] ch;
        logic [3:0] num;
        logic [1:0] frm;
        logic [1:0] pos;
        logic       sof;
        logic       eof;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: count of words accepted since the stream (re)started
    int   m_k    = 0;
    bit   m_done = 0;

    task automatic model(input logic v, input logic c, input logic [3:0] d);
        exp_t e;
        int   cc, nn, pp, sv;
        if (c) begin
            m_k    = 0;
            m_done = 0;
        end else if (v && !m_done) begin
            cc = m_k % NUM_CH;
            nn = m_k / NUM_CH;
            pp = nn % FRAME_LEN;
            sv = (d >= 8) ? int'(d) - 16 : int'(d);
            e.d    = sv[7:0];
            e.ch   = cc[0:0];
            e.num  = nn[3:0];
            e.frm  = 2'(nn / FRAME_LEN);
            e.pos  = pp[1:0];
            e.sof  = (pp == 0) && (cc == 0);
            e.last = (nn == TOTAL_DATA - 1) && (cc == NUM_CH - 1);
            e.eof  = ((pp == FRAME_LEN - 1) && (cc == NUM_CH - 1)) || e.last;
            q.push_back(e);
            m_k++;
            if (e.last) begin
                m_k    = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [3:0] d);
        @(posedge clk);
        #1;
        di_en  = v;
        clr    = c;
        data_i = d;
        model(v, c, d);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: decoupled from stimulus, runs on the falling edge
    initial begin : monitor
        exp_t e;
        exp_t act;
        exp_t held;
        held = '0;
        forever begin
            @(negedge clk);
            act = {data_o, ch, num, frm_idx, pos, sof, eof, last};
            if (!rst) begin
                checks++;
                if ({do_en, done, act} !== '0) begin
                    failures++;
                    $display("FAIL reset_zero actual=%h do_en=%b done=%b required=0",
                             act, do_en, done);
                end
                held = '0;
            end else if (do_en === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_do_en actual=%h required=no output", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL word actual d=%h ch=%0d num=%0d frm=%0d pos=%0d sof=%b eof=%b last=%b required d=%h ch=%0d num=%0d frm=%0d pos=%0d sof=%b eof=%b last=%b",
                                 data_o, ch, num, frm_idx, pos, sof, eof, last,
                                 e.d, e.ch, e.num, e.frm, e.pos, e.sof, e.eof, e.last);
                    end
                    held = e;
                    held.sof  = 1'b0;
                    held.eof  = 1'b0;
                    held.last = 1'b0;
                end
            end else begin
                checks++;
                if (do_en !== 1'b0 || act !== held) begin
                    failures++;
                    $display("FAIL idle_hold actual do_en=%b out=%h required do_en=0 out=%h",
                             do_en, act, held);
                end
            end
        end
    end

    initial begin : stimulus
        rst    = 1'b0;
        clr    = 1'b0;
        di_en  = 1'b0;
        data_i = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Full stream of 20 words, first one a negative sample
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'($urandom));
        checks++;
        if (data_o !== 8'hFA || sof !== 1'b1 || do_en !== 1'b1) begin
            failures++;
            $display("FAIL first_word actual data_o=%h sof=%b do_en=%b required data_o=fa sof=1 do_en=1",
                     data_o, sof, do_en);
        end
        for (int i = 2; i < 20; i++) step(1'b1, 1'b0, 4'($urandom));
        step(1'b0, 1'b0, 4'h0);
        check_bit("done_after_last", done, 1'b1);

        // Words while done are ignored; clear then restart
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'($urandom));
        check_bit("done_held", done, 1'b1);
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 4'($urandom));
        check_bit("done_cleared", done, 1'b0);
        step(1'b0, 1'b0, 4'h0);

        // Gapped input from a fresh stream
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 4'($urandom));
        step(1'b0, 1'b0, 4'($urandom));
        step(1'b0, 1'b0, 4'($urandom));
        step(1'b1, 1'b0, 4'($urandom));
        step(1'b0, 1'b0, 4'($urandom));
        step(1'b1, 1'b0, 4'($urandom));
        step(1'b0, 1'b0, 4'h0);

        // Clear coincident with a valid word drops that word
        for (int i = 0; i < 10; i++) step(1'b1, (i == 5), 4'($urandom));
        step(1'b0, 1'b0, 4'h0);

        // Asynchronous reset in the middle of a frame
        step(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'($urandom));
        step(1'b1, 1'b0, 4'($urandom));
        #2;
        rst   = 1'b0;
        di_en = 1'b0;
        q.delete();
        m_k    = 0;
        m_done = 0;
        #1;
        checks++;
        if ({do_en, data_o, ch, num, frm_idx, pos, sof, eof, last, done} !== '0) begin
            failures++;
            $display("FAIL async_reset actual do_en=%b data_o=%h num=%0d pos=%0d required all zero",
                     do_en, data_o, num, pos);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom));

        // Randomised traffic with occasional clears
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3), 4'($urandom));

        // Drain and confirm every expected word was produced
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual pending=%0d required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sample_indexer.md
Name: frame_sample_indexer

Overview:
- Parametrised successor to the front-end sample counter in the log-mel pipeline.
- Registers each incoming audio word and tags it with channel id, global sample index, frame index and in-frame position.
- Emits start-of-frame, end-of-frame and last-sample strobes for the downstream windowing/FFT stage.
- Supports interleaved multi-channel input, a sync clear, and end-of-stream stop; the previous counter had none of these.

Parameters:
- I_BW, 14, input sample width.
- O_BW, 14, output sample width. Must be >= I_BW.
- TOTAL_DATA, 15104, samples per channel per stream.
- FRAME_LEN, 512, samples per frame. Must be >= 2 and <= TOTAL_DATA.
- NUM_CH, 1, interleaved channels. Must be >= 1.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- clr, in, 1, synchronous clear of counters and done.
- di_en, in, 1, input word valid.
- data_i, in, I_BW, input sample (two's complement).
- do_en, out, 1, output valid; one-cycle pulse per accepted word.
- data_o, out, O_BW, registered sample, sign-extended.
- ch, out, max(1,$clog2(NUM_CH)), channel of data_o.
- num, out, $clog2(TOTAL_DATA), zero-based global sample index of data_o.
- frm_idx, out, $clog2(TOTAL_DATA/FRAME_LEN+1), zero-based frame number of data_o.
- pos, out, $clog2(FRAME_LEN), position within the frame, 0..FRAME_LEN-1.
- sof, out, 1, first word of a frame.
- eof, out, 1, final word of a frame.
- last, out, 1, final word of the stream.
- done, out, 1, stream complete; level signal.

Behaviour:
- Reset: while rst=0, every output is 0, including data_o, and the internal channel, sample, frame and position counters are 0.
- Accept: a word is accepted when di_en=1, clr=0 and done=0.
- Latency: exactly one cycle. In the cycle after an accepted word:
  - do_en=1.
  - data_o = sign-extended data_i.
  - ch, num, frm_idx and pos give that word's indices.
- No accept: do_en=0. data_o and all index outputs hold their last values.
- Channel order: ch runs 0..NUM_CH-1. The sample, frame and position counters advance only after the word with ch=NUM_CH-1. With NUM_CH=1, ch is always 0.
- Position: pos wraps FRAME_LEN-1 -> 0, and frm_idx increments on that wrap. pos always equals num mod FRAME_LEN.
- Strobes are registered alongside do_en and are 0 whenever do_en=0:
  - sof = (pos==0 && ch==0).
  - eof = (pos==FRAME_LEN-1 && ch==NUM_CH-1), OR-ed with last. A short final frame therefore still gets eof.
  - last = (num==TOTAL_DATA-1 && ch==NUM_CH-1).
- Done: goes to 1 in the same cycle that last=1 and stays 1. While done=1, di_en is ignored and no do_en is produced. The counters are already back at 0.
- clr=1:
  - Next cycle: counters=0, done=0, do_en=0, strobes=0.
  - data_o and the index outputs hold.
  - clr beats di_en in the same cycle: that word is dropped.
- Asynchronous reset mid-stream: all state and outputs go to 0 immediately. The first accepted word after release is index 0.
- Widths: counters are sized from the parameters and must never exceed their terminal values.

Test Plan (bench params TOTAL_DATA=10, FRAME_LEN=4, NUM_CH=2, I_BW=4, O_BW=8 unless stated):
- Reset, then di_en=1 with data_i=4'hA -> one cycle later: do_en=1, data_o=8'hFA, ch=0, num=0, pos=0, frm_idx=0, sof=1, eof=0.
- 20 consecutive words -> num sequence 0,0,1,1,…,9,9 with ch alternating 0,1. sof on words 0, 8 and 16. eof on words 7, 15 and 19 (19 is the short final frame, pos=1). last and done on word 19 only.
- After done=1, drive 3 more words -> do_en stays 0 and outputs hold. Then pulse clr and send one word -> do_en=1, num=0, ch=0, sof=1, done=0.
- Gapped input (di_en 1,0,0,1,0,1) -> do_en pulses exactly one cycle after each 1. Indices advance only on accepted words: (ch,num) = (0,0), (1,0), (0,1).
- clr and di_en asserted together at word 5 -> that word produces no do_en. The next accepted word has num=0, ch=0.
- Drop rst to 0 asynchronously between clock edges mid-frame (word 6) -> all outputs 0 before the next edge. Stream restarts at index 0 after release.
